execute_stage_md: RTL

Parametrised next-generation integer execute stage with an iterative RV32M/RV64M multiply/divide unit. Sits between ID/EX and EX/MEM: applies operand forwarding, runs single-cycle ALU ops and resolves branches, and runs MUL/DIV/REM ops over multiple cycles. A valid/ready handshake stalls the front end while an MD op is in flight and honours back-pressure from MEM. Owns the EX/MEM pipeline register and its valid bit.

---
 rtl/execute_pkg.sv | 57 +++++
 rtl/muldiv_iter.sv | 119 +++++++++++
 rtl/execute_stage_md.sv | 137 +++++++++++++
 3 files changed

// File: rtl/execute_pkg.sv
// Shared types and constants for the integer execute stage and its
// iterative multiply/divide unit.
package execute_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } md_state_e;

  localparam logic [1:0] FWD_OWN     = 2'd0;
  localparam logic [1:0] FWD_MEM     = 2'd1;
  localparam logic [1:0] FWD_WB      = 2'd2;
  localparam logic [1:0] FWD_MEM_ALT = 2'd3;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // BLT/BGE expect SUB in the ALU (N flag); BLTU/BGEU expect SLTU (Z flag).
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_EQ   = 3'd1;
  localparam logic [2:0] BR_NE   = 3'd2;
  localparam logic [2:0] BR_LT   = 3'd3;
  localparam logic [2:0] BR_GE   = 3'd4;
  localparam logic [2:0] BR_LTU  = 3'd5;
  localparam logic [2:0] BR_GEU  = 3'd6;
  localparam logic [2:0] BR_JALR = 3'd7;

  function automatic logic [63:0] div_min_value(input int xlen);
    div_min_value = 64'd1 << (xlen - 1);
  endfunction

  function automatic logic [63:0] div_all_ones(input int xlen);
    div_all_ones = {64{1'b1}} >> (64 - xlen);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign handling on entry and exit.
module muldiv_iter import execute_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            drain_ready,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            idle,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] DIV_MIN  = XLEN'(div_min_value(XLEN));
  localparam logic [XLEN-1:0] DIV_ONES = XLEN'(div_all_ones(XLEN));

  md_state_e         state, state_next;
  logic [5:0]        cnt;
  logic [2*XLEN-1:0] prod, prod_step, prod_fix;
  logic [XLEN-1:0]   opnd;
  md_op_e            op_q;
  logic              neg_q, neg_r;

  logic              is_div, a_signed, b_signed, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_trial;
  logic [XLEN-1:0]   div_rem;

  assign is_div   = op[2];
  assign a_signed = op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  assign b_signed = op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  assign sa       = a_signed & a[XLEN-1];
  assign sb       = b_signed & b[XLEN-1];
  assign mag_a    = sa ? -a : a;
  assign mag_b    = sb ? -b : b;
  assign div_zero = is_div & (b == '0);
  assign div_ovf  = (op == MD_DIV || op == MD_REM) && (a == DIV_MIN) && (b == DIV_ONES);

  // One iteration: multiply adds into the upper half then shifts right,
  // divide shifts the remainder left and keeps the trial difference if non-negative.
  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? opnd : '0)};
    div_trial = {prod[2*XLEN-1:XLEN], prod[XLEN-1]} - {1'b0, opnd};
    div_rem   = div_trial[XLEN] ? {prod[2*XLEN-2:XLEN], prod[XLEN-1]} : div_trial[XLEN-1:0];
    if (op_q[2]) prod_step = {div_rem, prod[XLEN-2:0], ~div_trial[XLEN]};
    else         prod_step = {mul_sum, prod[XLEN-1:1]};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (div_zero | div_ovf) ? FIN : CALC;
      CALC: if (cnt == 6'(XLEN-1)) state_next = FIN;
      FIN:  if (drain_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Special-case divisions preload the final quotient/remainder with signs cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      prod  <= '0;
      opnd  <= '0;
      op_q  <= MD_MUL;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= state_next;
      if (start && state == IDLE) begin
        op_q <= op;
        cnt  <= '0;
        if (div_zero) begin
          prod  <= {a, DIV_ONES};
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else if (div_ovf) begin
          prod  <= {{XLEN{1'b0}}, DIV_MIN};
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else if (is_div) begin
          prod  <= {{XLEN{1'b0}}, mag_a};
          opnd  <= mag_b;
          neg_q <= sa ^ sb;
          neg_r <= sa;
        end else begin
          prod  <= {{XLEN{1'b0}}, mag_b};
          opnd  <= mag_a;
          neg_q <= sa ^ sb;
          neg_r <= 1'b0;
        end
      end else if (state == CALC) begin
        prod <= prod_step;
        cnt  <= cnt + 6'd1;
      end
    end
  end

  always_comb begin
    prod_fix = neg_q ? -prod : prod;
    case (op_q)
      MD_MUL:                      result = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             result = neg_q ? -prod[XLEN-1:0] : prod[XLEN-1:0];
      default:                     result = neg_r ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
    endcase
  end

  assign idle = (state == IDLE);
  assign done = (state == FIN) & drain_ready & ~abort;

endmodule

// File: rtl/execute_stage_md.sv
// Integer execute stage: forwarding, single-cycle ALU, branch resolution,
// iterative M-extension unit and the EX/MEM pipeline register.
module execute_stage_md import execute_pkg::*; #(
  parameter int XLEN   = 32,
  parameter int PASS_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic              mem_ready_i,
  input  logic [XLEN-1:0]   data_a_i,
  input  logic [XLEN-1:0]   data_b_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [XLEN-1:0]   pc_plus_i,
  input  logic [XLEN-1:0]   data_from_mem,
  input  logic [XLEN-1:0]   data_from_wb,
  input  logic [1:0]        fwd_a_sel,
  input  logic [1:0]        fwd_b_sel,
  input  logic [1:0]        fwd_st_sel,
  input  logic [3:0]        alu_func,
  input  logic              is_md,
  input  logic [2:0]        md_op,
  input  logic              sel_pc,
  input  logic [2:0]        branch_sel,
  input  logic              branch_prediction_i,
  input  logic [PASS_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [XLEN-1:0]   result_o,
  output logic [XLEN-1:0]   store_data_o,
  output logic [PASS_W-1:0] ctrl_o,
  output logic              misprediction_o,
  output logic [XLEN-1:0]   correct_pc,
  output logic              md_busy_o
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0]   op_a, op_b, op_st, alu_out, md_result;
  logic              accept, drain_ready, md_idle, md_done, taken, alu_z, alu_n;
  logic [PASS_W-1:0] md_ctrl;

  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel, input logic [XLEN-1:0] own,
                                              input logic [XLEN-1:0] mem, input logic [XLEN-1:0] wb);
    case (sel)
      FWD_OWN: fwd_mux = own;
      FWD_WB:  fwd_mux = wb;
      default: fwd_mux = mem;
    endcase
  endfunction

  assign op_a  = fwd_mux(fwd_a_sel, data_a_i, data_from_mem, data_from_wb);
  assign op_b  = fwd_mux(fwd_b_sel, data_b_i, data_from_mem, data_from_wb);
  assign op_st = fwd_mux(fwd_st_sel, store_data_i, data_from_mem, data_from_wb);

  assign drain_ready = ~valid_o | mem_ready_i;
  assign ready_o     = md_idle & drain_ready;
  assign accept      = valid_i & ready_o & ~flush_i;
  assign md_busy_o   = ~md_idle;

  always_comb begin
    case (alu_func)
      ALU_ADD:   alu_out = op_a + op_b;
      ALU_SUB:   alu_out = op_a - op_b;
      ALU_AND:   alu_out = op_a & op_b;
      ALU_OR:    alu_out = op_a | op_b;
      ALU_XOR:   alu_out = op_a ^ op_b;
      ALU_SLL:   alu_out = op_a << op_b[SHW-1:0];
      ALU_SRL:   alu_out = op_a >> op_b[SHW-1:0];
      ALU_SRA:   alu_out = $signed(op_a) >>> op_b[SHW-1:0];
      ALU_SLT:   alu_out = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_out = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_PASSB: alu_out = op_b;
      default:   alu_out = '0;
    endcase
  end

  assign alu_z = (alu_out == '0);
  assign alu_n = alu_out[XLEN-1];

  always_comb begin
    case (branch_sel)
      BR_EQ, BR_GEU: taken = alu_z;
      BR_NE, BR_LTU: taken = ~alu_z;
      BR_LT:         taken = alu_n;
      BR_GE:         taken = ~alu_n;
      BR_JALR:       taken = 1'b1;
      default:       taken = 1'b0;
    endcase
  end

  assign misprediction_o = accept & ~is_md & (taken ^ branch_prediction_i);
  assign correct_pc      = (branch_sel == BR_JALR) ? alu_out : pc_plus_i;

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk         (clk),
    .reset       (reset),
    .start       (accept & is_md),
    .abort       (flush_i),
    .drain_ready (drain_ready),
    .op          (md_op_e'(md_op)),
    .a           (op_a),
    .b           (op_b),
    .idle        (md_idle),
    .done        (md_done),
    .result      (md_result)
  );

  // EX/MEM: ALU ops load at accept, MD ops when the unit drains; a flushed
  // op never writes, so older contents stay in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_o      <= 1'b0;
      result_o     <= '0;
      store_data_o <= '0;
      ctrl_o       <= '0;
      md_ctrl      <= '0;
    end else begin
      if (accept && is_md) md_ctrl <= ctrl_i;
      if (accept && !is_md) begin
        valid_o      <= 1'b1;
        result_o     <= sel_pc ? pc_plus_i : alu_out;
        store_data_o <= op_st;
        ctrl_o       <= ctrl_i;
      end else if (md_done) begin
        valid_o      <= 1'b1;
        result_o     <= md_result;
        store_data_o <= '0;
        ctrl_o       <= md_ctrl;
      end else if (mem_ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
